// File: rtl/tetris_pkg.sv
// Shared constants, FSM encoding and score table for the tetris line-clear engine.
package tetris_pkg;

  localparam int COLS    = 10;
  localparam int ROWS    = 20;
  localparam int MAP_W   = COLS * ROWS;
  localparam int SCORE_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  localparam logic [SCORE_W-1:0] PTS_1 = 16'd1;
  localparam logic [SCORE_W-1:0] PTS_2 = 16'd3;
  localparam logic [SCORE_W-1:0] PTS_3 = 16'd5;
  localparam logic [SCORE_W-1:0] PTS_4 = 16'd8;

  function automatic logic [SCORE_W-1:0] table_points(input logic [4:0] cnt);
    logic [SCORE_W-1:0] p;
    case (cnt)
      5'd0:    p = 16'd0;
      5'd1:    p = PTS_1;
      5'd2:    p = PTS_2;
      5'd3:    p = PTS_3;
      default: p = PTS_4;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/tetris_score_acc.sv
// Saturating score accumulator; TETRIS_SCORE_TABLE_EN selects classic table points
// instead of one point per removed row.
module tetris_score_acc
  import tetris_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_score,
  input  logic               commit,
  input  logic [4:0]         count,
  output logic [SCORE_W-1:0] score
);

  logic [SCORE_W-1:0] score_r;
  logic [SCORE_W-1:0] points_s;
  logic [SCORE_W:0]   sum_s;

  // points lookup and widened sum for saturation detect
  always_comb begin
`ifdef TETRIS_SCORE_TABLE_EN
    points_s = table_points(count);
`else
    points_s = {{(SCORE_W-5){1'b0}}, count};
`endif
    sum_s = {1'b0, score_r} + {1'b0, points_s};
  end

  // score register; clearing beats a same-cycle commit
  always_ff @(posedge clk) begin
    if (rst) begin
      score_r <= 16'd0;
    end else if (clr_score) begin
      score_r <= 16'd0;
    end else if (commit) begin
      score_r <= sum_s[SCORE_W] ? {SCORE_W{1'b1}} : sum_s[SCORE_W-1:0];
    end else begin
      score_r <= score_r;
    end
  end

  assign score = score_r;

endmodule

// File: rtl/tetris_line_clear.sv
// Sequential bottom-up row-elimination engine with compacted map and score output.
// Build option: TETRIS_SCORE_TABLE_EN (classic scoring table, see tetris_score_acc).
module tetris_line_clear
  import tetris_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [MAP_W-1:0]   map_in,
  input  logic               clr_score,
  output logic               busy,
  output logic               done,
  output logic [MAP_W-1:0]   map_out,
  output logic [SCORE_W-1:0] score,
  output logic [4:0]         lines
);

  state_t             state_r, state_n;
  logic [MAP_W-1:0]   work_r, work_n;
  logic [MAP_W-1:0]   map_out_r, map_out_n;
  logic [MAP_W-1:0]   shifted_s;
  logic [4:0]         row_r, row_n;
  logic [4:0]         count_r, count_n;
  logic [4:0]         lines_r, lines_n;
  logic               busy_r, busy_n;
  logic               done_r, done_n;
  logic [COLS-1:0]    row_bits_s;
  logic               row_full_s;
  logic               commit_s;

  // row-full detect on the current pointer, and the map with that row squeezed out
  always_comb begin
    row_bits_s = work_r[row_r*COLS +: COLS];
    row_full_s = &row_bits_s;
    shifted_s  = work_r;
    shifted_s[COLS-1:0] = {COLS{1'b0}};
    for (int y = 1; y < ROWS; y++) begin
      if (5'(y) <= row_r) begin
        shifted_s[y*COLS +: COLS] = work_r[(y-1)*COLS +: COLS];
      end else begin
        shifted_s[y*COLS +: COLS] = work_r[y*COLS +: COLS];
      end
    end
  end

  // next-state and datapath updates
  always_comb begin
    state_n   = state_r;
    work_n    = work_r;
    row_n     = row_r;
    count_n   = count_r;
    busy_n    = busy_r;
    done_n    = 1'b0;
    map_out_n = map_out_r;
    lines_n   = lines_r;
    commit_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          work_n  = map_in;
          row_n   = 5'd19;
          count_n = 5'd0;
          busy_n  = 1'b1;
          state_n = ST_SCAN;
        end else begin
          busy_n  = 1'b0;
        end
      end
      ST_SCAN: begin
        // a removal keeps the pointer so the row dropped into place is rechecked
        if (row_full_s) begin
          work_n  = shifted_s;
          count_n = count_r + 5'd1;
        end else if (row_r == 5'd0) begin
          state_n = ST_COMMIT;
        end else begin
          row_n   = row_r - 5'd1;
        end
      end
      ST_COMMIT: begin
        map_out_n = work_r;
        lines_n   = count_r;
        done_n    = 1'b1;
        busy_n    = 1'b0;
        commit_s  = 1'b1;
        state_n   = ST_IDLE;
      end
      default: begin
        busy_n  = 1'b0;
        state_n = ST_IDLE;
      end
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      work_r    <= {MAP_W{1'b0}};
      row_r     <= 5'd0;
      count_r   <= 5'd0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      map_out_r <= {MAP_W{1'b0}};
      lines_r   <= 5'd0;
    end else begin
      state_r   <= state_n;
      work_r    <= work_n;
      row_r     <= row_n;
      count_r   <= count_n;
      busy_r    <= busy_n;
      done_r    <= done_n;
      map_out_r <= map_out_n;
      lines_r   <= lines_n;
    end
  end

  tetris_score_acc u_score (
    .clk       (clk),
    .rst       (rst),
    .clr_score (clr_score),
    .commit    (commit_s),
    .count     (count_r),
    .score     (score)
  );

  assign busy    = busy_r;
  assign done    = done_r;
  assign map_out = map_out_r;
  assign lines   = lines_r;

endmodule

// File: tb/tb_tetris_line_clear.sv
// Directed and randomized bench for tetris_line_clear against a row-list reference model.
module tb_tetris_line_clear;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [199:0] map_in;
  logic         clr_score;
  logic         busy;
  logic         done;
  logic [199:0] map_out;
  logic [15:0]  score;
  logic [4:0]   lines;

  int tests = 0;
  int fails = 0;
  int model_score = 0;

  always #5 clk = ~clk;

  tetris_line_clear dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .map_in    (map_in),
    .clr_score (clr_score),
    .busy      (busy),
    .done      (done),
    .map_out   (map_out),
    .score     (score),
    .lines     (lines)
  );

  task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pts(input int k);
`ifdef TETRIS_SCORE_TABLE_EN
    if (k == 0) return 0;
    if (k == 1) return 1;
    if (k == 2) return 3;
    if (k == 3) return 5;
    return 8;
`else
    return k;
`endif
  endfunction

  // Keep the non-full rows in bottom-up order and stack them on the floor.
  task automatic model(input logic [199:0] m, output logic [199:0] res, output int k);
    logic [9:0] kept[$];
    logic [9:0] row;
    k = 0;
    res = 200'd0;
    for (int y = 19; y >= 0; y--) begin
      row = m[y*10 +: 10];
      if (row == 10'h3FF) k++;
      else kept.push_back(row);
    end
    for (int i = 0; i < kept.size(); i++) res[(19-i)*10 +: 10] = kept[i];
  endtask

  task automatic run_op(input string tag, input logic [199:0] m, input bit clr_commit,
                        input bit second, input logic [199:0] m2);
    logic [199:0] exp_map;
    int k;
    int edges;
    int s;
    bit seen;
    model(m, exp_map, k);
    s = model_score + pts(k);
    if (s > 65535) s = 65535;
    model_score = clr_commit ? 0 : s;
    @(negedge clk);
    start = 1'b1;
    map_in = m;
    @(posedge clk);
    #1;
    start = 1'b0;
    map_in = 200'd0;
    edges = 1;
    chk({tag, " busy_rise"}, 200'(busy), 200'd1);
    seen = 1'b0;
    while (!seen && edges < 60) begin
      if (second && edges == 5) begin
        start = 1'b1;
        map_in = m2;
      end
      if (clr_commit && edges == 21 + k) clr_score = 1'b1;
      @(posedge clk);
      #1;
      edges++;
      start = 1'b0;
      clr_score = 1'b0;
      if (done) seen = 1'b1;
    end
    chk({tag, " latency"}, 200'(edges), 200'(22 + k));
    chk({tag, " map_out"}, map_out, exp_map);
    chk({tag, " lines"}, 200'(lines), 200'(k));
    chk({tag, " score"}, 200'(score), 200'(model_score));
    chk({tag, " busy_fall"}, 200'(busy), 200'd0);
    @(posedge clk);
    #1;
    chk({tag, " done_single"}, 200'(done), 200'd0);
  endtask

  function automatic logic [199:0] rand_map();
    logic [199:0] m;
    for (int y = 0; y < 20; y++) begin
      if ($urandom_range(2) == 0) m[y*10 +: 10] = 10'h3FF;
      else m[y*10 +: 10] = 10'($urandom);
    end
    return m;
  endfunction

  initial begin
    logic [199:0] m;
    int dcount;
    rst = 1'b1;
    start = 1'b0;
    clr_score = 1'b0;
    map_in = 200'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 200'(busy), 200'd0);
    chk("reset done", 200'(done), 200'd0);
    chk("reset map_out", map_out, 200'd0);
    chk("reset score", 200'(score), 200'd0);
    chk("reset lines", 200'(lines), 200'd0);
    rst = 1'b0;

    run_op("empty", 200'd0, 1'b0, 1'b0, 200'd0);

    m = 200'd0;
    m[199:190] = 10'h3FF;
    m[183] = 1'b1;
    run_op("row19", m, 1'b0, 1'b0, 200'd0);
    chk("row19 bit193", map_out, 200'd1 << 193);

    m = 200'd0;
    m[199:160] = {40{1'b1}};
    m[150] = 1'b1;
    run_op("tetris", m, 1'b0, 1'b0, 200'd0);
    chk("tetris bit190", map_out, 200'd1 << 190);

    run_op("second_start", rand_map(), 1'b0, 1'b1, {200{1'b1}});

    for (int i = 0; i < 8; i++) run_op($sformatf("rand%0d", i), rand_map(), 1'b0, 1'b0, 200'd0);

    run_op("full_map", {200{1'b1}}, 1'b0, 1'b0, 200'd0);

    run_op("clr_at_commit", rand_map(), 1'b1, 1'b0, 200'd0);

    @(negedge clk);
    force dut.u_score.score_r = 16'hFFFC;
    @(posedge clk);
    #1;
    release dut.u_score.score_r;
    model_score = 65532;
    m = 200'd0;
    m[199:160] = {40{1'b1}};
    m[150] = 1'b1;
    run_op("saturate", m, 1'b0, 1'b0, 200'd0);

    @(negedge clk);
    start = 1'b1;
    map_in = rand_map();
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_score = 0;
    chk("midrst busy", 200'(busy), 200'd0);
    chk("midrst map_out", map_out, 200'd0);
    chk("midrst score", 200'(score), 200'd0);
    chk("midrst done", 200'(done), 200'd0);
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) dcount++;
    end
    chk("midrst no_done", 200'(dcount), 200'd0);

    run_op("after_rst", rand_map(), 1'b0, 1'b0, 200'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tetris_line_clear.md
Name: tetris_line_clear

Overview:
- Sequential row-elimination engine upstream of the playfield renderer.
- Triggered when the game controller locks a piece into the 200-bit playfield.
- Scans the 10x20 map bottom-up, removes every full row, and shifts the rows above it down.
- Publishes the compacted map and a running 16-bit score, which the renderer consumes.

Parameters:
- COLS, 10, playfield width in cells.
- ROWS, 20, playfield height in cells.
- SCORE_W, 16, score register width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse: lock event; map_in is valid in the same cycle.
- map_in  in  200  playfield snapshot. Bit y*COLS+x is cell (x,y); y=0 is the top row, y=19 the bottom row.
- clr_score  in  1  zeroes the score (new game).
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when map_out and score are updated.
- map_out  out  200  compacted playfield, same bit layout as map_in.
- score  out  16  accumulated score.
- lines  out  5  number of rows removed by the last operation (0..20).

Behaviour:
- Reset values: busy=0, done=0, map_out=0, score=0, lines=0, state IDLE.
- FSM states: IDLE, SCAN, COMMIT.
- IDLE:
  - On start, capture map_in into the work register, set row pointer r=19 and count=0, go to SCAN.
  - busy goes high from the following cycle.
- SCAN (one step per clock):
  - If work row r is all ones: rows r..1 take the contents of rows r-1..0, row 0 is cleared, count+1. r is not decremented, so the new row r is rechecked.
  - Otherwise, if r==0 go to COMMIT; else r-1.
- Latency: scan takes exactly 20+k clocks, where k is the number of rows removed.
- COMMIT (one clock):
  - map_out<=work, lines<=count, score<=sat(score+points(count)).
  - done=1 for this one cycle; busy drops at the same edge; return to IDLE.
- Timing: with start sampled at edge N, done is high in the cycle after edge N+21+k, i.e. 22+k edges from start.
- start while busy: ignored; no queuing.
- clr_score:
  - Takes priority over the COMMIT score update in the same cycle; score becomes 0.
  - Does not affect map_out, lines, or the FSM.
- Score arithmetic: saturating at 16'hFFFF; never wraps.
- rst mid-operation: abort immediately and return to reset values; the partial work map is discarded.
- map_out holds its value between operations. The renderer sees no intermediate shift states.
- Empty map or no full rows: k=0, map_out=map_in, points=0, done still pulses.

Optional Feature:
- Macro: TETRIS_SCORE_TABLE_EN.
- Defined: points use the classic table, count 0/1/2/3/>=4 gives 0/1/3/5/8.
- Undefined: points = count (1 point per removed row).
- Timing and every other behaviour are identical in both builds.

Decomposition:
- Package tetris_pkg holds:
  - COLS=10, ROWS=20, MAP_W=200.
  - FSM state encoding.
  - Score table constants PTS_1..PTS_4 = 1,3,5,8.
- Sub-module tetris_score_acc holds the score register, points lookup (macro-dependent), saturation, and clr_score priority.
- Row-full detect and row shift stay inline in tetris_line_clear.

Test Plan:
- Empty map, start -> done 22 edges after start; map_out=0, lines=0, score unchanged (0).
- Only row 19 full (bits 190..199) plus cell (3,18) -> done at 23 edges; map_out has only bit 193 set; lines=1; score=1.
- Rows 16..19 full plus cell (0,15) -> lines=4; map_out has only bit 190 set; score=8 with TETRIS_SCORE_TABLE_EN, 4 without; done at 26 edges.
- Score preloaded to 16'hFFFC by repeated ops, then a 4-row clear -> score=16'hFFFF (saturated, no wrap).
- Second start pulse 5 cycles after the first -> ignored; exactly one done pulse; result matches the first snapshot.
- rst asserted 10 cycles into a scan -> next cycle busy=0, map_out=0, score=0, no done pulse. clr_score asserted coincident with COMMIT -> score=0.
